// File: rtl/uart_rx_core_if.sv
// Receive-side result bundle of the UART RX engine.
// The core drives it (master); the RX FIFO / register block consumes it (slave).
interface uart_rx_core_if;
  logic [7:0] rx_data;
  logic       rx_pe;
  logic       rx_fe;
  logic       rx_bi;
  logic       rx_push;
  logic       rx_busy;

  modport master (
    output rx_data,
    output rx_pe,
    output rx_fe,
    output rx_bi,
    output rx_push,
    output rx_busy
  );

  modport slave (
    input rx_data,
    input rx_pe,
    input rx_fe,
    input rx_bi,
    input rx_push,
    input rx_busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART serial receive engine: synchronises rx, detects the start edge,
// oversamples each bit on the baud tick and delivers one word plus
// PE/FE/BI status with a single-cycle push toward the RX FIFO.
module uart_rx_core #(
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           baud_pulse,
  input  logic           rx,
  input  logic [1:0]     wls,
  input  logic           pen,
  input  logic           eps,
  input  logic           sp,
  uart_rx_core_if.master rx_if
);

  localparam int TW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [TW-1:0] TICK_HALF = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OSR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs_prev_q;
  logic                   rxs;
  logic                   start_edge;

  state_t                 state_q;
  logic [TW-1:0]          tick_q;
  logic [2:0]             bit_q;
  logic [7:0]             data_q;
  logic                   par_q;
  logic [1:0]             wls_q;
  logic                   pen_q;
  logic                   eps_q;
  logic                   sp_q;

  logic [7:0]             rx_data_q;
  logic                   rx_pe_q;
  logic                   rx_fe_q;
  logic                   rx_bi_q;
  logic                   rx_push_q;
  logic                   rx_busy_q;

  logic [2:0]             last_bit;
  logic                   exp_par;

  assign rxs        = sync_q[SYNC_STAGES-1];
  assign start_edge = rxs_prev_q & ~rxs;
  assign last_bit   = {1'b0, wls_q} + 3'd4;
  // Unreceived upper bits of data_q are zero, so the reduction covers only the word.
  assign exp_par    = sp_q ? ~eps_q : (eps_q ? ^data_q : ~^data_q);

  // Metastability chain on the asynchronous line plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
      rxs_prev_q <= rxs;
    end
  end

  // Frame FSM: start validation, data/parity/stop sampling and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      wls_q     <= '0;
      pen_q     <= 1'b0;
      eps_q     <= 1'b0;
      sp_q      <= 1'b0;
      rx_data_q <= '0;
      rx_pe_q   <= 1'b0;
      rx_fe_q   <= 1'b0;
      rx_bi_q   <= 1'b0;
      rx_push_q <= 1'b0;
      rx_busy_q <= 1'b0;
    end else begin
      rx_push_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_q   <= S_START;
            tick_q    <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            wls_q     <= wls;
            pen_q     <= pen;
            eps_q     <= eps;
            sp_q      <= sp;
            rx_busy_q <= 1'b1;
          end
        end
        S_START: begin
          if (baud_pulse) begin
            if (tick_q == TICK_HALF) begin
              tick_q <= '0;
              if (rxs) begin
                state_q   <= S_IDLE;
                rx_busy_q <= 1'b0;
              end else begin
                state_q <= S_DATA;
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        S_DATA: begin
          if (baud_pulse) begin
            if (tick_q == TICK_LAST) begin
              tick_q        <= '0;
              data_q[bit_q] <= rxs;
              if (bit_q == last_bit) begin
                state_q <= pen_q ? S_PARITY : S_STOP;
              end else begin
                bit_q <= bit_q + 3'd1;
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        S_PARITY: begin
          if (baud_pulse) begin
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              par_q   <= rxs;
              state_q <= S_STOP;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        S_STOP: begin
          if (baud_pulse) begin
            if (tick_q == TICK_LAST) begin
              tick_q    <= '0;
              state_q   <= S_IDLE;
              rx_data_q <= data_q;
              rx_pe_q   <= pen_q & (par_q != exp_par);
              rx_fe_q   <= ~rxs;
              rx_bi_q   <= (data_q == 8'h00) & (~pen_q | ~par_q) & ~rxs;
              rx_push_q <= 1'b1;
              rx_busy_q <= 1'b0;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_if.rx_data = rx_data_q;
  assign rx_if.rx_pe   = rx_pe_q;
  assign rx_if.rx_fe   = rx_fe_q;
  assign rx_if.rx_bi   = rx_bi_q;
  assign rx_if.rx_push = rx_push_q;
  assign rx_if.rx_busy = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames from the feature list
// plus randomized frames checked against a frame-level reference model.
module tb_uart_rx_core;
  localparam int OSR = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_pulse;
  logic       rx;
  logic [1:0] wls;
  logic       pen;
  logic       eps;
  logic       sp;

  int baud_div = 1;
  int div_cnt  = 0;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  // monitor state
  int         push_cnt = 0;
  int         push_run = 0;
  int         max_push_run = 0;
  int         busy_run = 0;
  int         last_busy_len = 0;
  int         busy_rises = 0;
  int         busy_at_push = 0;
  logic       busy_prev = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic       last_pe = 1'b0;
  logic       last_fe = 1'b0;
  logic       last_bi = 1'b0;

  uart_rx_core_if rx_if ();

  uart_rx_core #(.OSR(OSR), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_pulse (baud_pulse),
    .rx         (rx),
    .wls        (wls),
    .pen        (pen),
    .eps        (eps),
    .sp         (sp),
    .rx_if      (rx_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) div_cnt <= (div_cnt >= baud_div - 1) ? 0 : div_cnt + 1;
  assign baud_pulse = (div_cnt == 0);

  always @(negedge clk) begin
    if (rx_if.rx_push === 1'b1) begin
      push_cnt++;
      push_run++;
      if (push_run > max_push_run) max_push_run = push_run;
      last_data     = rx_if.rx_data;
      last_pe       = rx_if.rx_pe;
      last_fe       = rx_if.rx_fe;
      last_bi       = rx_if.rx_bi;
      last_busy_len = busy_run;
      if (rx_if.rx_busy !== 1'b0) busy_at_push++;
    end else begin
      push_run = 0;
    end
    if (rx_if.rx_busy === 1'b1) begin
      busy_run++;
      if (busy_prev !== 1'b1) busy_rises++;
    end else begin
      busy_run = 0;
    end
    busy_prev = rx_if.rx_busy;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: what the receiver should report for a frame as sent on the line.
  task automatic model(input logic [7:0] d, input logic [1:0] w, input logic p_en, input logic p_eps,
                       input logic p_sp, input logic par_bit, input logic stop_bit,
                       output logic [7:0] ed, output logic epe, output logic efe, output logic ebi);
    int nb;
    int ones;
    logic want;
    nb   = 5 + int'(w);
    ed   = 8'(d & ((1 << nb) - 1));
    ones = $countones(ed);
    if (p_sp) want = ~p_eps;                 // stick parity: fixed bit
    else if (p_eps) want = (ones % 2) == 1;  // even: total ones incl. parity even
    else want = (ones % 2) == 0;             // odd: total ones incl. parity odd
    epe = p_en && (par_bit != want);
    efe = (stop_bit == 1'b0);
    ebi = (ed == 8'h00) && (!p_en || !par_bit) && (stop_bit == 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] w, input logic p_en,
                            input logic p_eps, input logic p_sp, input logic par_bit,
                            input logic stop_bit, input bit scramble);
    int bit_clks;
    logic [31:0] junk;
    bit_clks = OSR * baud_div;
    wls = w; pen = p_en; eps = p_eps; sp = p_sp;
    rx = 1'b0;
    hold(bit_clks);
    if (scramble) begin
      junk = $urandom;
      wls = junk[1:0]; pen = junk[2]; eps = junk[3]; sp = junk[4];
    end
    for (int i = 0; i < 5 + int'(w); i++) begin
      rx = d[i];
      hold(bit_clks);
    end
    if (p_en) begin
      rx = par_bit;
      hold(bit_clks);
    end
    rx = stop_bit;
    hold(bit_clks);
    rx = 1'b1;
    hold(bit_clks * 2);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] d, input logic [1:0] w,
                          input logic p_en, input logic p_eps, input logic p_sp,
                          input logic par_bit, input logic stop_bit, input bit scramble);
    logic [7:0] ed;
    logic epe, efe, ebi;
    send_frame(d, w, p_en, p_eps, p_sp, par_bit, stop_bit, scramble);
    model(d, w, p_en, p_eps, p_sp, par_bit, stop_bit, ed, epe, efe, ebi);
    exp_cnt++;
    $display("%s: sent=%02h wls=%0d pen=%0d eps=%0d sp=%0d par=%0d stop=%0d div=%0d got=%02h pe=%0d fe=%0d bi=%0d",
             tag, d, w, p_en, p_eps, p_sp, par_bit, stop_bit, baud_div,
             last_data, last_pe, last_fe, last_bi);
    check({tag, ".push_count"}, push_cnt, exp_cnt);
    check({tag, ".data"}, last_data, ed);
    check({tag, ".pe"}, last_pe, epe);
    check({tag, ".fe"}, last_fe, efe);
    check({tag, ".bi"}, last_bi, ebi);
  endtask

  initial begin
    logic [7:0] d;
    logic [31:0] r;
    int rises_before;

    rx = 1'b1; rst = 1'b1; wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    hold(5);
    check("reset.data", rx_if.rx_data, 8'h00);
    check("reset.pe", rx_if.rx_pe, 1'b0);
    check("reset.fe", rx_if.rx_fe, 1'b0);
    check("reset.bi", rx_if.rx_bi, 1'b0);
    check("reset.push", rx_if.rx_push, 1'b0);
    check("reset.busy", rx_if.rx_busy, 1'b0);
    rst = 1'b0;
    hold(5);

    // 8N1 0xA5 with baud tick every clock
    baud_div = 1;
    do_frame("8n1_a5", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    $display("8n1_a5: busy_len=%0d", last_busy_len);
    check("8n1_a5.busy_len_ok", (last_busy_len >= 140 && last_busy_len <= 160), 1'b1);

    // 5-bit odd parity, good and bad parity bit
    do_frame("5o1_good", 8'h10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_frame("5o1_bad", 8'h10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // 8E1 0x3C with stop bit forced low
    do_frame("8e1_fe", 8'h3C, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Break: line low for two full 8N1 frames, then idle
    wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    rx = 1'b0;
    hold(20 * OSR);
    rx = 1'b1;
    hold(3 * OSR);
    exp_cnt++;
    $display("break: pushes=%0d got=%02h pe=%0d fe=%0d bi=%0d", push_cnt, last_data, last_pe, last_fe, last_bi);
    check("break.push_count", push_cnt, exp_cnt);
    check("break.data", last_data, 8'h00);
    check("break.bi", last_bi, 1'b1);
    check("break.fe", last_fe, 1'b1);
    check("break.pe", last_pe, 1'b0);

    // Short glitch on idle line: false start
    rises_before = busy_rises;
    rx = 1'b0;
    hold(4);
    rx = 1'b1;
    hold(4 * OSR);
    $display("glitch: busy_rises=%0d pushes=%0d busy=%0d", busy_rises - rises_before, push_cnt, rx_if.rx_busy);
    check("glitch.busy_pulsed", busy_rises, rises_before + 1);
    check("glitch.no_push", push_cnt, exp_cnt);
    check("glitch.busy_low", rx_if.rx_busy, 1'b0);

    // Reset in the middle of the data bits aborts the frame
    d = 8'h5A;
    wls = 2'b11; pen = 1'b0;
    rx = 1'b0;
    hold(OSR);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      hold(OSR);
    end
    hold(5);
    rst = 1'b1;
    rx = 1'b1;
    hold(1);
    rst = 1'b0;
    check("abort.busy", rx_if.rx_busy, 1'b0);
    check("abort.data_cleared", rx_if.rx_data, 8'h00);
    hold(4 * OSR);
    $display("abort: pushes=%0d", push_cnt);
    check("abort.no_push", push_cnt, exp_cnt);
    do_frame("after_abort", 8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized frames with varying tick rate and mid-frame config changes
    for (int n = 0; n < 16; n++) begin
      string tag;
      r = $urandom;
      baud_div = $urandom_range(1, 3);
      hold(8);
      tag = $sformatf("rand%0d", n);
      do_frame(tag, r[7:0], r[9:8], r[10], r[11], r[12], r[13],
               ($urandom_range(0, 4) != 0), 1'b1);
    end

    check("push_width", max_push_run, 1);
    check("busy_clear_at_push", busy_at_push, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
